hilo_ctrl: RTL and testbench
============================

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 34, meaning clock edges from the edge that samples mult_go to the edge that captures mult_hi/mult_lo.
REQ-002 SHALL have parameter DIV_LAT, default 34, with the same meaning for div_go and div_hi/div_lo.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start_mult  input  1  control-unit request to run a multiply.
REQ-006 SHALL have port start_div  input  1  control-unit request to run a divide.
REQ-007 SHALL have port mult_hi, mult_lo  input  32 each  multiplier result words.
REQ-008 SHALL have port div_hi, div_lo, div_zero  input  32/32/1  divider remainder, quotient and divide-by-zero flag.
REQ-009 SHALL have port mthi, mtlo, wdata  input  1/1/32  direct writes of wdata into HI or LO.
REQ-010 SHALL have port sel_hi  input  1  read select (1 = HI, 0 = LO).
REQ-011 SHALL have port mult_go, div_go  output  1 each  registered one-cycle start pulses to the arithmetic units.
REQ-012 SHALL have port hi_q, lo_q, rdata  output  32 each  HI, LO and the selected word.
REQ-013 SHALL have port busy, done, div0_exc  output  1 each  stall request, completion pulse, exception pulse.

Function
REQ-014 SHALL implement states IDLE, GO_M, GO_D, WAIT.
- IDLE -> GO_M on start_mult; IDLE -> GO_D on start_div. start_mult wins when both are high (div request dropped).
- GO_M/GO_D -> WAIT after one cycle; counter loaded to 1.
- WAIT: at each edge, if the counter equals the latency of the active operation, then capture and return to IDLE; otherwise increment the counter.
REQ-015 SHALL hold mult_go high exactly during GO_M and div_go exactly during GO_D.
REQ-016 SHALL capture at edge E_LAT, where E0 is the edge ending the GO cycle.
REQ-017 SHALL have an internal counter 6 bits wide; LAT values 2..63 are legal.
REQ-018 SHALL on multiply capture load hi_q <= mult_hi and lo_q <= mult_lo.
REQ-019 SHALL on divide capture load hi_q <= div_hi and lo_q <= div_lo when div_zero = 0.
- When div_zero = 1, hi_q and lo_q are left unchanged.
- div0_exc pulses for one cycle after that capture edge.
REQ-020 SHALL pulse done for exactly one cycle after every capture edge, including divide-by-zero.
REQ-021 SHALL drive busy = 1 in GO_M, GO_D and WAIT, and 0 in IDLE.
REQ-022 SHALL ignore start_mult, start_div, mthi and mtlo while busy.
REQ-023 SHALL in IDLE apply mthi (hi_q <= wdata) and mtlo (lo_q <= wdata).
- Both may apply in the same edge.
- A start accepted in the same edge is also honoured; its later capture overwrites the write.
REQ-024 SHALL drive rdata combinationally as sel_hi ? hi_q : lo_q; reads are legal in any state.

Reset
REQ-025 SHALL when reset = 0 at a rising edge force state IDLE, counter 0, hi_q = lo_q = 0, and mult_go = div_go = busy = done = div0_exc = 0.
REQ-026 SHALL on reset mid-operation discard the in-flight result; no done pulse and no capture follow reset.
REQ-027 SHALL give reset priority over all other inputs in the same edge.

Structure
REQ-028 SHALL place the state encoding and the default MULT_LAT/DIV_LAT values in shared package hilo_pkg.
REQ-029 SHALL implement the load/increment/compare counter as sub-module lat_counter (inputs load, en, lat; output hit).

Verification
REQ-030 SHALL cover reset: hold reset = 0 for 2 cycles -> hi_q = lo_q = 0, busy = 0, rdata = 0.
REQ-031 SHALL cover multiply: start_mult pulse with mult_hi = 0x00000001, mult_lo = 0xFFFFFFFE held stable -> mult_go high for 1 cycle, busy high 35 cycles, hi_q = 0x00000001 and lo_q = 0xFFFFFFFE after E34, done high for 1 cycle.
REQ-032 SHALL cover divide-by-zero: preload hi_q = 0x12345678 via mthi, then start_div with div_zero = 1 -> after E34 hi_q = 0x12345678, div0_exc and done each high for 1 cycle.
REQ-033 SHALL cover direct access: mthi with wdata = 0xDEADBEEF, then mtlo with wdata = 0x0000CAFE -> rdata = 0xDEADBEEF at sel_hi = 1 and 0x0000CAFE at sel_hi = 0.
REQ-034 SHALL cover request conflicts:
- start_mult and start_div in the same cycle -> only mult_go pulses.
- start_div at WAIT counter 5 -> ignored.
- mtlo during WAIT -> lo_q unchanged.
REQ-035 SHALL cover reset mid-operation: assert reset at WAIT counter 10 -> IDLE next cycle, hi_q = lo_q = 0, and no done pulse within the next 40 cycles.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register controller: FSM encoding,
// counter width and default arithmetic-unit latencies.
package hilo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GO_M = 2'd1,
      GO_D = 2'd2,
      WAIT = 2'd3
   } state_t;

   localparam int CNT_W        = 6;
   localparam int DEF_MULT_LAT = 34;
   localparam int DEF_DIV_LAT  = 34;

endpackage

// File: rtl/hilo_ctrl_lat_counter.sv
// Latency counter: load to 1, count up while enabled, flag when the
// count matches the latency of the operation in flight.
module lat_counter
   import hilo_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] lat,
   output logic             hit
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= CNT_W'(1);
      end else if (en) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign hit = (count_reg == lat);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: launches multiply/divide units, waits a fixed
// latency, captures results, and serves direct HI/LO writes and reads.
module hilo_ctrl
   import hilo_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   input  logic        div_zero,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        sel_hi,
   output logic        mult_go,
   output logic        div_go,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        div0_exc
);

   localparam logic [CNT_W-1:0] MULT_LAT_W = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_LAT_W  = CNT_W'(DIV_LAT);

   state_t      state_reg, state_next;
   logic        op_div_reg, op_div_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;
   logic        done_reg, done_next;
   logic        div0_reg, div0_next;
   logic        cnt_load, cnt_en, cnt_hit;
   logic [CNT_W-1:0] lat_sel;

   assign lat_sel = op_div_reg ? DIV_LAT_W : MULT_LAT_W;

   lat_counter u_lat_counter (
      .clock (clock),
      .reset (reset),
      .load  (cnt_load),
      .en    (cnt_en),
      .lat   (lat_sel),
      .hit   (cnt_hit)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg  <= IDLE;
         op_div_reg <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         done_reg   <= 1'b0;
         div0_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         op_div_reg <= op_div_next;
         hi_reg     <= hi_next;
         lo_reg     <= lo_next;
         done_reg   <= done_next;
         div0_reg   <= div0_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      op_div_next = op_div_reg;
      hi_next     = hi_reg;
      lo_next     = lo_reg;
      done_next   = 1'b0;
      div0_next   = 1'b0;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
      case (state_reg)
         IDLE: begin
            // Direct writes land now; a start in the same edge captures later.
            if (mthi) hi_next = wdata;
            if (mtlo) lo_next = wdata;
            if (start_mult) begin
               state_next  = GO_M;
               op_div_next = 1'b0;
            end else if (start_div) begin
               state_next  = GO_D;
               op_div_next = 1'b1;
            end
         end
         GO_M, GO_D: begin
            state_next = WAIT;
            cnt_load   = 1'b1;
         end
         WAIT: begin
            if (cnt_hit) begin
               state_next = IDLE;
               done_next  = 1'b1;
               if (!op_div_reg) begin
                  hi_next = mult_hi;
                  lo_next = mult_lo;
               end else if (div_zero) begin
                  div0_next = 1'b1;
               end else begin
                  hi_next = div_hi;
                  lo_next = div_lo;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign mult_go  = (state_reg == GO_M);
   assign div_go   = (state_reg == GO_D);
   assign busy     = (state_reg != IDLE);
   assign done     = done_reg;
   assign div0_exc = div0_reg;
   assign hi_q     = hi_reg;
   assign lo_q     = lo_reg;
   assign rdata    = sel_hi ? hi_reg : lo_reg;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: stimulus pushes expected captures, a
// monitor pops and checks them whenever done pulses.
module tb_hilo_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start_mult = 1'b0, start_div = 1'b0;
   logic [31:0] mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;
   logic        div_zero = 1'b0, mthi = 1'b0, mtlo = 1'b0, sel_hi = 1'b0;
   logic [31:0] wdata = '0;
   logic        mult_go, div_go, busy, done, div0_exc;
   logic [31:0] hi_q, lo_q, rdata;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        div0;
   } exp_t;

   exp_t sb[$];
   int   total = 0, bad = 0;
   int   mgo_cnt = 0, dgo_cnt = 0, done_cnt = 0;

   hilo_ctrl dut (
      .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
      .div_zero(div_zero), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .sel_hi(sel_hi),
      .mult_go(mult_go), .div_go(div_go), .hi_q(hi_q), .lo_q(lo_q), .rdata(rdata),
      .busy(busy), .done(done), .div0_exc(div0_exc)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clock) begin
      exp_t e;
      if (mult_go) mgo_cnt++;
      if (div_go)  dgo_cnt++;
      if (done)    done_cnt++;
      if (div0_exc && !done) check("div0_without_done", 32'(div0_exc), 32'd0);
      if (done) begin
         if (sb.size() == 0) begin
            check("done_unexpected", 32'(done), 32'd0);
         end else begin
            e = sb.pop_front();
            check("cap_hi", hi_q, e.hi);
            check("cap_lo", lo_q, e.lo);
            check("cap_div0", 32'(div0_exc), 32'(e.div0));
         end
      end
   end

   task automatic wait_idle(output int bcyc);
      bit seen = 0;
      bcyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (busy) begin
            bcyc++;
            seen = 1;
         end else if (seen) begin
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL wait_idle: timeout after 200 cycles, busy=%0b", busy);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int bc, m0, d0, n0;

      // Reset held for two edges
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_hi", hi_q, 32'd0);
      check("rst_lo", lo_q, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      tick();
      reset = 1'b1;

      // Direct access
      mthi = 1'b1; wdata = 32'hDEADBEEF;
      tick();
      mthi = 1'b0; mtlo = 1'b1; wdata = 32'h0000CAFE;
      tick();
      mtlo = 1'b0; sel_hi = 1'b1;
      #1 check("rd_hi", rdata, 32'hDEADBEEF);
      sel_hi = 1'b0;
      #1 check("rd_lo", rdata, 32'h0000CAFE);

      // Multiply
      tick();
      mult_hi = 32'h00000001; mult_lo = 32'hFFFFFFFE;
      m0 = mgo_cnt; d0 = dgo_cnt;
      sb.push_back('{hi: 32'h00000001, lo: 32'hFFFFFFFE, div0: 1'b0});
      start_mult = 1'b1;
      tick();
      start_mult = 1'b0;
      wait_idle(bc);
      check("mul_busy_cycles", 32'(bc), 32'd35);
      check("mul_go_pulses", 32'(mgo_cnt - m0), 32'd1);
      check("mul_no_div_go", 32'(dgo_cnt - d0), 32'd0);

      // Divide by zero keeps HI/LO
      tick();
      mthi = 1'b1; wdata = 32'h12345678;
      tick();
      mthi = 1'b0;
      div_hi = 32'hAAAA0000; div_lo = 32'h0000BBBB; div_zero = 1'b1;
      d0 = dgo_cnt;
      sb.push_back('{hi: 32'h12345678, lo: 32'hFFFFFFFE, div0: 1'b1});
      start_div = 1'b1;
      tick();
      start_div = 1'b0;
      wait_idle(bc);
      check("dz_busy_cycles", 32'(bc), 32'd35);
      check("dz_go_pulses", 32'(dgo_cnt - d0), 32'd1);
      check("dz_hi_kept", hi_q, 32'h12345678);

      // Normal divide
      tick();
      div_zero = 1'b0; div_hi = 32'h00000007; div_lo = 32'h00000003;
      sb.push_back('{hi: 32'h00000007, lo: 32'h00000003, div0: 1'b0});
      start_div = 1'b1;
      tick();
      start_div = 1'b0;
      wait_idle(bc);
      check("div_busy_cycles", 32'(bc), 32'd35);

      // Conflicts: both starts, then start_div and mtlo during WAIT
      tick();
      mult_hi = 32'hA5A5A5A5; mult_lo = 32'h5A5A5A5A;
      m0 = mgo_cnt; d0 = dgo_cnt;
      sb.push_back('{hi: 32'hA5A5A5A5, lo: 32'h5A5A5A5A, div0: 1'b0});
      start_mult = 1'b1; start_div = 1'b1;
      tick();
      start_mult = 1'b0; start_div = 1'b0;
      repeat (5) tick();
      start_div = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF0000;
      tick();
      start_div = 1'b0; mtlo = 1'b0;
      @(negedge clock);
      check("wait_mtlo_ignored", lo_q, 32'h00000003);
      wait_idle(bc);
      check("conf_mult_go", 32'(mgo_cnt - m0), 32'd1);
      check("conf_no_div_go", 32'(dgo_cnt - d0), 32'd0);

      // Reset mid-operation, with competing inputs in the reset edge
      tick();
      mult_hi = 32'h11111111; mult_lo = 32'h22222222;
      start_mult = 1'b1;
      tick();
      start_mult = 1'b0;
      repeat (10) tick();
      reset = 1'b0; start_mult = 1'b1; mthi = 1'b1; wdata = 32'h33333333;
      tick();
      reset = 1'b1; start_mult = 1'b0; mthi = 1'b0;
      @(negedge clock);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_hi", hi_q, 32'd0);
      check("mid_rst_lo", lo_q, 32'd0);
      n0 = done_cnt;
      repeat (40) @(negedge clock);
      check("mid_rst_no_done", 32'(done_cnt - n0), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
